// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
// Holds the result-source select encodings, the load funct3 codes and the
// write-back FSM state type used by wb_pipe and wb_load_align.
package wb_pkg;

  // Result source select carried with each instruction into WB.
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_PCN  = 2'b01;
  localparam logic [1:0] WB_SEL_RSVD = 2'b10;
  localparam logic [1:0] WB_SEL_LOAD = 2'b11;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // IDLE: nothing valid in WB. RUN: valid instruction (or load completing).
  // WAIT: load waiting for its data. DRAIN: killed load, response still owed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: purely combinational load data extraction.
// Ports:
//   raw_i  - raw memory word as returned by the data memory
//   f3_i   - load funct3 (size and signedness)
//   offs_i - byte offset of the load address inside the word
//   data_o - selected, sign- or zero-extended load value
// Offset bits below the natural alignment of the access are ignored.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFFS_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [2:0]            f3_i,
  input  logic [OFFS_W-1:0]     offs_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam bit IS64 = (DATA_WIDTH == 64);

  logic [63:0] raw64_s;
  logic [2:0]  boff_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] word_s;
  logic [63:0] ext_s;

  // Work on a 64-bit view so both widths share one datapath; for the 32-bit
  // build boff_s[2] is always zero, so the word lane is fixed at bit 0.
  assign raw64_s = 64'(raw_i);
  assign boff_s  = 3'(offs_i);
  assign byte_s  = 8'(raw64_s >> {boff_s, 3'b000});
  assign half_s  = 16'(raw64_s >> {boff_s[2:1], 4'b0000});
  assign word_s  = 32'(raw64_s >> {boff_s[2], 5'b00000});

  // Size/sign selection; LWU and LD fall back to LW on a 32-bit datapath.
  always_comb begin
    ext_s = {{32{word_s[31]}}, word_s};
    case (f3_i)
      F3_LB:   ext_s = {{56{byte_s[7]}}, byte_s};
      F3_LBU:  ext_s = {56'h0, byte_s};
      F3_LH:   ext_s = {{48{half_s[15]}}, half_s};
      F3_LHU:  ext_s = {48'h0, half_s};
      F3_LW:   ext_s = {{32{word_s[31]}}, word_s};
      F3_LWU:  ext_s = IS64 ? {32'h0, word_s} : {{32{word_s[31]}}, word_s};
      F3_LD:   ext_s = IS64 ? raw64_s : {{32{word_s[31]}}, word_s};
      default: ext_s = {{32{word_s[31]}}, word_s};
    endcase
  end

  assign data_o = DATA_WIDTH'(ext_s);

endmodule

// File: rtl/wb_pipe.sv
// wb_pipe: write-back pipeline stage with load-data wait handling.
// Ports:
//   clk, rst          - clock; synchronous active-low reset
//   valid_m..ld_offsm - instruction fields arriving from the memory stage
//   flush             - kill the instruction currently in WB
//   dmem_rvalid/rdata - load response from data memory
//   reg_wew, rdw, result - register file write port
//   valid_w           - WB stage holds a valid instruction
//   wb_stall          - hold upstream stages (load data not yet available)
//   retire_cnt        - count of completed instructions, wraps
module wb_pipe
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_m,
  input  logic                            reg_wem,
  input  logic [4:0]                      rdm,
  input  logic [ADDR_WIDTH-1:0]           pcnm,
  input  logic [DATA_WIDTH-1:0]           alu_resultm,
  input  logic [1:0]                      wb_ctrm,
  input  logic [2:0]                      ld_f3m,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] ld_offsm,
  input  logic                            flush,
  input  logic                            dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]           dmem_rdata,
  output logic                            reg_wew,
  output logic [4:0]                      rdw,
  output logic [DATA_WIDTH-1:0]           result,
  output logic                            valid_w,
  output logic                            wb_stall,
  output logic [CNT_WIDTH-1:0]            retire_cnt
);

  localparam int OFFS_W = $clog2(DATA_WIDTH / 8);

  wb_state_e state_q, state_d, capture_st_s;

  logic                  valid_q;
  logic                  reg_we_q;
  logic [4:0]            rd_q;
  logic [ADDR_WIDTH-1:0] pcn_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [1:0]            wb_ctr_q;
  logic [2:0]            ld_f3_q;
  logic [OFFS_W-1:0]     ld_offs_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  drain_s;
  logic                  waiting_s;
  logic                  stall_s;
  logic                  complete_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] result_s;

  wb_load_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFS_W     (OFFS_W)
  ) u_align (
    .raw_i  (dmem_rdata),
    .f3_i   (ld_f3_q),
    .offs_i (ld_offs_q),
    .data_o (load_data_s)
  );

  // Handshake decode and next-state logic for the WB FSM.
  always_comb begin
    capture_st_s = valid_m ? ST_RUN : ST_IDLE;
    drain_s      = (state_q == ST_DRAIN);
    // In DRAIN valid_q is already cleared, so only a live load can wait.
    waiting_s    = valid_q & (wb_ctr_q == WB_SEL_LOAD) & ~dmem_rvalid & ~drain_s;
    // DRAIN releases the stall in the cycle the discarded response arrives,
    // so capture resumes at that edge.
    stall_s      = waiting_s | (drain_s & ~dmem_rvalid);
    complete_s   = valid_q & ~waiting_s & ~drain_s & ~flush;
    state_d      = state_q;
    case (state_q)
      ST_DRAIN: begin
        if (dmem_rvalid) begin
          state_d = capture_st_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_IDLE, ST_RUN, ST_WAIT: begin
        if (waiting_s) begin
          if (flush) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = capture_st_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage register: capture when not stalled; a flushed waiting load is
  // invalidated in place while its response is drained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      rd_q      <= 5'd0;
      pcn_q     <= '0;
      alu_q     <= '0;
      wb_ctr_q  <= 2'b00;
      ld_f3_q   <= 3'b000;
      ld_offs_q <= '0;
    end else if (!stall_s) begin
      valid_q   <= valid_m;
      reg_we_q  <= reg_wem;
      rd_q      <= rdm;
      pcn_q     <= pcnm;
      alu_q     <= alu_resultm;
      wb_ctr_q  <= wb_ctrm;
      ld_f3_q   <= ld_f3m;
      ld_offs_q <= ld_offsm;
    end else if (waiting_s && flush) begin
      valid_q   <= 1'b0;
    end
  end

  // Retire counter next value.
  always_comb begin
    if (complete_s) begin
      cnt_d = cnt_q + CNT_WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Result source mux; the reserved select behaves like the ALU path.
  always_comb begin
    result_s = alu_q;
    case (wb_ctr_q)
      WB_SEL_ALU:  result_s = alu_q;
      WB_SEL_PCN:  result_s = DATA_WIDTH'(pcn_q);
      WB_SEL_RSVD: result_s = alu_q;
      WB_SEL_LOAD: result_s = load_data_s;
      default:     result_s = alu_q;
    endcase
  end

  assign reg_wew    = complete_s & reg_we_q & (rd_q != 5'd0);
  assign rdw        = rd_q;
  assign result     = result_s;
  assign valid_w    = valid_q;
  assign wb_stall   = stall_s;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe: self-checking bench for wb_pipe (32-bit datapath, 4-bit retire
// counter so wrap-around is reachable). A transaction-level model tracks the
// instruction sitting in WB plus an "owed discarded response" flag and predicts
// every output each cycle; directed sequences precede a randomized run.
module tb_wb_pipe;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, valid_m, reg_wem, flush, dmem_rvalid;
  logic [4:0]    rdm;
  logic [AW-1:0] pcnm;
  logic [DW-1:0] alu_resultm, dmem_rdata;
  logic [1:0]    wb_ctrm, ld_offsm;
  logic [2:0]    ld_f3m;
  logic          reg_wew, valid_w, wb_stall;
  logic [4:0]    rdw;
  logic [DW-1:0] result;
  logic [CW-1:0] retire_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;

  typedef struct {
    bit        valid;
    bit        we;
    bit [4:0]  rd;
    bit [31:0] pcn;
    bit [31:0] alu;
    bit [1:0]  ctr;
    bit [2:0]  f3;
    bit [1:0]  offs;
  } instr_t;

  instr_t m_wb;
  bit     m_drain;
  int     m_retired;

  always #5 clk = ~clk;

  wb_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_m     (valid_m),
    .reg_wem     (reg_wem),
    .rdm         (rdm),
    .pcnm        (pcnm),
    .alu_resultm (alu_resultm),
    .wb_ctrm     (wb_ctrm),
    .ld_f3m      (ld_f3m),
    .ld_offsm    (ld_offsm),
    .flush       (flush),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .reg_wew     (reg_wew),
    .rdw         (rdw),
    .result      (result),
    .valid_w     (valid_w),
    .wb_stall    (wb_stall),
    .retire_cnt  (retire_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load value from size/sign rules using plain arithmetic on the raw word.
  function automatic bit [31:0] load_value(bit [2:0] f3, bit [1:0] offs, bit [31:0] raw);
    int unsigned b, h;
    b = (raw >> (8 * offs)) % 256;
    h = (raw >> (16 * (offs / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic instr_t m_inputs();
    instr_t t;
    t.valid = valid_m;  t.we  = reg_wem;     t.rd   = rdm;
    t.pcn   = pcnm;     t.alu = alu_resultm; t.ctr  = wb_ctrm;
    t.f3    = ld_f3m;   t.offs = ld_offsm;
    return t;
  endfunction

  task automatic model_reset();
    m_wb      = '{default: 0};
    m_drain   = 1'b0;
    m_retired = 0;
  endtask

  task automatic set_m(input bit v, input bit we, input bit [4:0] rd, input bit [1:0] ctr,
                       input bit [31:0] alu, input bit [31:0] pcn, input bit [2:0] f3,
                       input bit [1:0] offs);
    valid_m = v; reg_wem = we; rdm = rd; wb_ctrm = ctr;
    alu_resultm = alu; pcnm = pcn; ld_f3m = f3; ld_offsm = offs;
  endtask

  task automatic idle_m();
    set_m(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 3'd0, 2'd0);
  endtask

  // One clock: predict and compare outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit        is_load, waiting, stall, done, wr;
    bit [31:0] res;
    #1;
    is_load = m_wb.valid && (m_wb.ctr == 2'b11);
    waiting = !m_drain && is_load && !dmem_rvalid;
    stall   = m_drain ? !dmem_rvalid : waiting;
    done    = m_wb.valid && !m_drain && !waiting && !flush;
    wr      = done && m_wb.we && (m_wb.rd != 5'd0);
    case (m_wb.ctr)
      2'b01:   res = m_wb.pcn;
      2'b11:   res = load_value(m_wb.f3, m_wb.offs, dmem_rdata);
      default: res = m_wb.alu;
    endcase
    check_eq("reg_wew", 32'(reg_wew), 32'(wr));
    check_eq("rdw", 32'(rdw), 32'(m_wb.rd));
    check_eq("valid_w", 32'(valid_w), 32'(m_wb.valid));
    check_eq("wb_stall", 32'(wb_stall), 32'(stall));
    check_eq("retire_cnt", 32'(retire_cnt), 32'(m_retired));
    if (m_wb.valid && !stall) check_eq("result", result, res);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (done) m_retired = (m_retired + 1) % (1 << CW);
      if (m_drain) begin
        if (dmem_rvalid) begin
          m_drain = 1'b0;
          m_wb    = m_inputs();
        end
      end else if (waiting) begin
        if (flush) begin
          m_wb.valid = 1'b0;
          m_drain    = 1'b1;
        end
      end else begin
        m_wb = m_inputs();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    idle_m();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_cnt", 32'(retire_cnt), 32'h0);
    cycle();
    rst = 1'b1;

    // ALU op writes rd 5.
    set_m(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 3'd0, 2'd0);
    cycle();
    idle_m();
    #1;
    check_eq("alu_wew", 32'(reg_wew), 32'h1);
    check_eq("alu_result", result, 32'h1234);
    cycle();
    #1;
    check_eq("alu_cnt", 32'(retire_cnt), 32'h1);

    // JAL to x0: link value shown, no write, still retires.
    set_m(1'b1, 1'b1, 5'd0, 2'b01, 32'hAAAA, 32'h104, 3'd0, 2'd0);
    cycle();
    idle_m();
    #1;
    check_eq("jal_result", result, 32'h104);
    check_eq("jal_wew", 32'(reg_wew), 32'h0);
    cycle();
    #1;
    check_eq("jal_cnt", 32'(retire_cnt), 32'h2);

    // LB then LBU at offset 3 with zero-wait data.
    set_m(1'b1, 1'b1, 5'd3, 2'b11, 32'h0, 32'h0, 3'b000, 2'd3);
    cycle();
    set_m(1'b1, 1'b1, 5'd4, 2'b11, 32'h0, 32'h0, 3'b100, 2'd3);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1;
    check_eq("lb_result", result, 32'hFFFF_FF80);
    check_eq("lb_stall", 32'(wb_stall), 32'h0);
    cycle();
    idle_m();
    #1;
    check_eq("lbu_result", result, 32'h0000_0080);
    cycle();
    dmem_rvalid = 1'b0;

    // LH with data three cycles late; upstream op must be held.
    set_m(1'b1, 1'b1, 5'd7, 2'b11, 32'h0, 32'h0, 3'b001, 2'd0);
    cycle();
    set_m(1'b1, 1'b1, 5'd9, 2'b00, 32'h55, 32'h0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lh_stall", 32'(wb_stall), 32'h1);
      check_eq("lh_wew", 32'(reg_wew), 32'h0);
      cycle();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8001;
    #1;
    check_eq("lh_result", result, 32'hFFFF_8001);
    check_eq("lh_release", 32'(wb_stall), 32'h0);
    cycle();
    dmem_rvalid = 1'b0;
    idle_m();
    #1;
    check_eq("lh_next_rd", 32'(rdw), 32'd9);
    cycle();

    // Flush during WAIT, drain the stale response, then a normal ALU op.
    set_m(1'b1, 1'b1, 5'd10, 2'b11, 32'h0, 32'h0, 3'b010, 2'd0);
    cycle();
    idle_m();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    check_eq("drain_stall", 32'(wb_stall), 32'h1);
    cycle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_DEAD;
    set_m(1'b1, 1'b1, 5'd11, 2'b00, 32'h77, 32'h0, 3'd0, 2'd0);
    #1;
    check_eq("drain_wew", 32'(reg_wew), 32'h0);
    cycle();
    dmem_rvalid = 1'b0;
    idle_m();
    #1;
    check_eq("post_drain_wew", 32'(reg_wew), 32'h1);
    check_eq("post_drain_res", result, 32'h77);
    cycle();

    // Reset while waiting on a load; late response must be ignored.
    set_m(1'b1, 1'b1, 5'd12, 2'b11, 32'h0, 32'h0, 3'b010, 2'd0);
    cycle();
    idle_m();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("rst_wait_valid", 32'(valid_w), 32'h0);
    check_eq("rst_wait_stall", 32'(wb_stall), 32'h0);
    check_eq("rst_wait_cnt", 32'(retire_cnt), 32'h0);
    cycle();
    dmem_rvalid = 1'b0;

    // Counter wrap: 16 back-to-back retirements on a 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      set_m(1'b1, 1'b1, 5'd1, 2'b00, 32'(i), 32'h0, 3'd0, 2'd0);
      cycle();
    end
    idle_m();
    #1;
    check_eq("wrap_pre", 32'(retire_cnt), 32'd15);
    cycle();
    #1;
    check_eq("wrap_zero", 32'(retire_cnt), 32'd0);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 49) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata  = $urandom;
      set_m($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            2'($urandom_range(0, 3)), $urandom, $urandom,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/data width; legal values 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, PC width; SHALL be <= DATA_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 64, retire-counter width.
REQ-004 Ports, in order: clk in 1, sole clock; rst in 1, synchronous active-low reset (rst==0 at rising clk edge resets).
REQ-005 valid_m in 1 instruction present; reg_wem in 1 write enable; rdm in 5 dest reg; pcnm in ADDR_WIDTH PC+4; alu_resultm in DATA_WIDTH.
REQ-006 wb_ctrm in 2 source select; ld_f3m in 3 load funct3; ld_offsm in log2(DATA_WIDTH/8) byte offset of load address.
REQ-007 flush in 1 kill WB contents; dmem_rvalid in 1 load data valid; dmem_rdata in DATA_WIDTH raw load word.
REQ-008 reg_wew out 1; rdw out 5; result out DATA_WIDTH; valid_w out 1; wb_stall out 1 (hold upstream); retire_cnt out CNT_WIDTH.

Function
REQ-009 Stage register (valid, reg_we, rd, pcn, alu_result, wb_ctr, ld_f3, ld_offs) SHALL load from *m inputs at clk edge when wb_stall==0, hold when wb_stall==1.
REQ-010 wb_ctr: 2'b00 alu_result; 2'b01 pcn zero-extended to DATA_WIDTH; 2'b11 aligned load data; 2'b10 reserved, result = alu_result.
REQ-011 Load alignment: LB 000/LBU 100 byte at ld_offs; LH 001/LHU 101 half at ld_offs[msb:1]; LW 010 word (64-bit: ld_offs[2]); LWU 110, LD 011 only when DATA_WIDTH==64, else treated as LW.
REQ-012 Signed loads sign-extend, unsigned zero-extend to DATA_WIDTH; offset bits below natural alignment ignored (no misalignment trap).
REQ-013 FSM states IDLE (no valid instr), RUN (valid non-load, or load completing), WAIT (load, no data yet), DRAIN (flushed load, response outstanding).
REQ-014 Load in WB with dmem_rvalid==0 -> WAIT; wb_stall=1, reg_wew=0.
REQ-015 In WB-load or WAIT with dmem_rvalid==1: result from dmem_rdata same cycle, reg_wew=reg_we, wb_stall=0, stage advances next edge (zero-wait load completes in one cycle).
REQ-016 wb_stall SHALL be combinational: 1 in WAIT/load-without-data and DRAIN, else 0.
REQ-017 reg_wew = valid & reg_we & (rdw!=0) & not waiting & not flush; x0 never written.
REQ-018 flush==1: current WB contents invalidated at next edge, no write this cycle; flush in WAIT or on load lacking data -> DRAIN.
REQ-019 DRAIN: first dmem_rvalid consumed and discarded, then capture resumes (IDLE/RUN per valid_m) next edge; flush during DRAIN has no extra effect.
REQ-020 dmem_rvalid in IDLE or RUN-non-load ignored.
REQ-021 retire_cnt +1 per cycle where a valid instruction completes (reg_we irrelevant); wraps modulo 2^CNT_WIDTH; flushed instr not counted.
REQ-022 valid_w reflects stage register valid bit.

Reset
REQ-023 On rst==0 edge: state IDLE, all stage register fields 0, retire_cnt 0; thus reg_wew=0, rdw=0, result=0, valid_w=0, wb_stall=0.
REQ-024 Reset mid-WAIT/DRAIN returns to IDLE; no DRAIN entered; rvalid after reset ignored until a load is captured.

Structure
REQ-025 Shared package wb_pkg: wb_ctr encodings, load funct3 constants, FSM state type.
REQ-026 One combinational sub-module wb_load_align (raw word, f3, offs -> extended data); FSM, stage register, counter in wb_pipe.

Verification
REQ-027 ALU op: valid_m=1, reg_wem=1, rdm=5, wb_ctrm=00, alu=0x1234 -> next cycle reg_wew=1, rdw=5, result=0x1234, retire_cnt 0->1.
REQ-028 JAL: wb_ctrm=01, pcnm=0x104 -> result=0x00000104; rdm=0 -> reg_wew=0, retire_cnt still increments.
REQ-029 LB, offs=3, rdata=0x80FF_0000 with rvalid in WB cycle -> result=0xFFFF_FF80, no stall; LBU same -> 0x0000_0080.
REQ-030 LH, rvalid 3 cycles late -> wb_stall=1 three cycles, reg_wew=0, stage held; then rdata=0x0000_8001 offs=0 -> result=0xFFFF_8001, wb_stall=0.
REQ-031 Flush during WAIT -> no write, DRAIN; next rvalid (0xDEAD) discarded, no write; following ALU op writes normally.
REQ-032 rst=0 asserted during WAIT -> next cycle all outputs 0, IDLE; retire_cnt preloaded near 2^CNT_WIDTH-1 wraps to 0.
